fixed_point_alu: RTL and testbench

Multi-cycle signed fixed-point arithmetic unit with a start/done handshake. It performs add, subtract, multiply, divide and integer power on two-operand Q(I.F) numbers. It serves as the compute engine of stack_machine, which loads a/b/op, pulses start, and waits for done before consuming result.

---
 rtl/fixed_point_pkg.sv | 31 +++
 rtl/fixed_point_divider.sv | 76 +++++++
 rtl/fixed_point_alu.sv | 237 +++++++++++++++++++++++
 tb/tb_fixed_point_alu.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point ALU and its clients (e.g. stack_machine).
// Holds the operation encodings, the Q8.8 helper constants and the ALU state type.
package fixed_point_pkg;

  // Operation encodings; 5..7 are reserved and produce zero.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_POW = 3'd4;

  // Default Q8.8 format shared with stack_machine.
  localparam int unsigned Q_INT_WIDTH  = 8;
  localparam int unsigned Q_FRAC_WIDTH = 8;
  localparam int unsigned Q_WIDTH      = Q_INT_WIDTH + Q_FRAC_WIDTH;

  localparam logic [Q_WIDTH-1:0] Q_ONE = Q_WIDTH'(1) << Q_FRAC_WIDTH;
  localparam logic [Q_WIDTH-1:0] Q_MAX = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] Q_MIN = {1'b1, {(Q_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StAddSub,
    StMul,
    StDiv,
    StPowMul,
    StPowDiv,
    StDone
  } state_e;

endpackage

// File: rtl/fixed_point_divider.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - load dividend/divisor and begin (DividendWidth iterations follow)
//   dividend  - unsigned numerator
//   divisor   - unsigned denominator (zero yields an all-ones quotient)
//   quotient  - unsigned quotient, valid when done pulses
//   done      - one-cycle pulse after the last iteration
module fixed_point_divider #(
  parameter int unsigned DividendWidth = 24,
  parameter int unsigned DivisorWidth  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DividendWidth-1:0] dividend,
  input  logic [DivisorWidth-1:0]  divisor,
  output logic [DividendWidth-1:0] quotient,
  output logic                     done
);

  localparam int unsigned CntWidth = $clog2(DividendWidth + 1);
  localparam logic [CntWidth-1:0] CntInit = CntWidth'(DividendWidth);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(1);

  // The dividend register shifts out MSB-first while quotient bits shift in at the LSB.
  logic [DividendWidth-1:0] quo_q;
  // One spare bit so every remainder bit feeds the trial subtraction.
  logic [DivisorWidth:0]    rem_q;
  logic [DivisorWidth-1:0]  den_q;
  logic [CntWidth-1:0]      cnt_q;
  logic                     busy_q;
  logic                     done_q;

  logic [DivisorWidth+1:0]  shifted;
  logic [DivisorWidth+1:0]  trial;
  logic                     fits;

  always_comb begin
    shifted = {rem_q, quo_q[DividendWidth-1]};
    trial   = shifted - {2'b00, den_q};
    fits    = ~trial[DivisorWidth+1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        quo_q  <= dividend;
        rem_q  <= '0;
        den_q  <= divisor;
        cnt_q  <= CntInit;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        rem_q <= fits ? trial[DivisorWidth:0] : shifted[DivisorWidth:0];
        quo_q <= {quo_q[DividendWidth-2:0], fits};
        cnt_q <= cnt_q - CntLast;
        if (cnt_q == CntLast) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;
  assign done     = done_q;

endmodule

// File: rtl/fixed_point_alu.sv
// Multi-cycle saturating signed Q(I.F) ALU: add, sub, mul, div and integer power.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (aborts any operation)
//   start     - request, sampled only in idle or in the done cycle
//   op        - OP_ADD/SUB/MUL/DIV/POW, 5..7 reserved (result 0)
//   a, b      - signed Q(I.F) operands, latched on start
//   result    - signed Q(I.F) result, updated with done and held until the next done
//   done      - one-cycle completion pulse
module fixed_point_alu
  import fixed_point_pkg::*;
#(
  parameter int unsigned INTEGER_PART_WIDTH    = 8,
  parameter int unsigned FRACTIONAL_PART_WIDTH = 8
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  input  logic [2:0]                                          op,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] a,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] b,
  output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] result,
  output logic                                                done
);

  localparam int unsigned I = INTEGER_PART_WIDTH;
  localparam int unsigned F = FRACTIONAL_PART_WIDTH;
  localparam int unsigned N = I + F;

  localparam logic [N-1:0] QOne = N'(1) << F;
  localparam logic [N-1:0] QMax = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] QMin = {1'b1, {(N-1){1'b0}}};

  state_e                 state_q;
  logic [2:0]             op_q;
  logic [N-1:0]           a_q;
  logic [N-1:0]           b_q;
  logic [N-1:0]           acc_q;
  logic [N-1:0]           result_q;
  logic                   done_q;
  logic signed [2*N-1:0]  prod_q;
  logic                   mul_phase_q;
  logic [I-1:0]           pow_cnt_q;
  logic                   pow_neg_q;
  logic                   div_start_q;

  // Clamp an (N+1)-bit sum: overflow iff the two top bits disagree.
  function automatic logic [N-1:0] sat_narrow(input logic [N:0] v);
    if (v[N] == v[N-1]) begin
      return v[N-1:0];
    end else begin
      return v[N] ? QMin : QMax;
    end
  endfunction

  // Clamp a 2N-bit value: in range iff the top N+1 bits are all copies of the sign.
  function automatic logic [N-1:0] sat_wide(input logic [2*N-1:0] v);
    if (v[2*N-1:N-1] == {(N+1){v[2*N-1]}}) begin
      return v[N-1:0];
    end else begin
      return v[2*N-1] ? QMin : QMax;
    end
  endfunction

  // Add/sub at N+1 bits so the carry out is visible to the saturator.
  logic [N:0] sum_add;
  logic [N:0] sum_sub;
  assign sum_add = {a_q[N-1], a_q} + {b_q[N-1], b_q};
  assign sum_sub = {a_q[N-1], a_q} - {b_q[N-1], b_q};

  // Shared multiplier: a*b for MUL, acc*a for the POW repeated-multiply loop.
  logic [N-1:0]          mul_x;
  logic [N-1:0]          mul_y;
  logic signed [2*N-1:0] mul_full;
  logic [2*N-1:0]        mul_shift;
  logic [N-1:0]          mul_sat;

  always_comb begin
    mul_x = a_q;
    mul_y = b_q;
    if (state_q == StPowMul) begin
      mul_x = acc_q;
      mul_y = a_q;
    end
    mul_full  = $signed({{N{mul_x[N-1]}}, mul_x}) * $signed({{N{mul_y[N-1]}}, mul_y});
    mul_shift = prod_q >>> F;  // arithmetic shift floors toward -inf
    mul_sat   = sat_wide(mul_shift);
  end

  // Divider works on magnitudes; sign and saturation are applied afterwards.
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N+F-1:0] div_quo;
  logic           div_done;
  logic           div_neg;
  logic [N-1:0]   div_res;

  assign a_mag   = a_q[N-1] ? -a_q : a_q;
  assign b_mag   = b_q[N-1] ? -b_q : b_q;
  assign div_neg = a_q[N-1] ^ b_q[N-1];

  fixed_point_divider #(
    .DividendWidth(N + F),
    .DivisorWidth (N)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start_q),
    .dividend({a_mag, {F{1'b0}}}),
    .divisor (b_mag),
    .quotient(div_quo),
    .done    (div_done)
  );

  always_comb begin
    div_res = '0;
    if (b_q == '0) begin
      if (a_q != '0) begin
        div_res = a_q[N-1] ? QMin : QMax;
      end
    end else if (!div_neg) begin
      div_res = (|div_quo[N+F-1:N-1]) ? QMax : div_quo[N-1:0];
    end else begin
      // Negative side reaches one further: magnitude 2^(N-1) is exactly QMin.
      div_res = ((|div_quo[N+F-1:N]) || (div_quo[N-1] && |div_quo[N-2:0])) ?
                QMin : -div_quo[N-1:0];
    end
  end

  // Exponent k = floor(b); its magnitude is the number of factors in a^|k|.
  logic [I-1:0] k_in;
  logic [I-1:0] k_abs;
  assign k_in  = b[N-1:F];
  assign k_abs = b[N-1] ? -k_in : k_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      prod_q      <= '0;
      mul_phase_q <= 1'b0;
      pow_cnt_q   <= '0;
      pow_neg_q   <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      div_start_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            op_q        <= op;
            a_q         <= a;
            b_q         <= b;
            acc_q       <= a;
            mul_phase_q <= 1'b0;
            pow_cnt_q   <= k_abs;
            pow_neg_q   <= b[N-1];
            case (op)
              OP_MUL:  state_q <= StMul;
              OP_DIV: begin
                state_q     <= StDiv;
                div_start_q <= 1'b1;
              end
              OP_POW:  state_q <= StPowMul;
              default: state_q <= StAddSub;  // ADD, SUB and reserved codes
            endcase
          end else begin
            state_q <= StIdle;
          end
        end
        StAddSub: begin
          case (op_q)
            OP_ADD:  result_q <= sat_narrow(sum_add);
            OP_SUB:  result_q <= sat_narrow(sum_sub);
            default: result_q <= '0;
          endcase
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StMul: begin
          if (!mul_phase_q) begin
            prod_q      <= mul_full;
            mul_phase_q <= 1'b1;
          end else begin
            result_q <= mul_sat;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDiv, StPowDiv: begin
          if (div_done) begin
            result_q <= div_res;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StPowMul: begin
          if (pow_cnt_q == '0) begin
            result_q <= QOne;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else if (!mul_phase_q) begin
            if (pow_cnt_q == I'(1)) begin
              if (!pow_neg_q) begin
                result_q <= acc_q;
                done_q   <= 1'b1;
                state_q  <= StDone;
              end else begin
                // Reciprocal reuses the DIV path with operands 1.0 / acc.
                a_q         <= QOne;
                b_q         <= acc_q;
                div_start_q <= 1'b1;
                state_q     <= StPowDiv;
              end
            end else begin
              prod_q      <= mul_full;
              mul_phase_q <= 1'b1;
            end
          end else begin
            acc_q       <= mul_sat;
            pow_cnt_q   <= pow_cnt_q - I'(1);
            mul_phase_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fixed_point_alu.sv
// Self-checking bench for fixed_point_alu in Q8.8: directed vectors with literal
// expectations plus a cycle-by-cycle monitor against an integer-arithmetic model.
module tb_fixed_point_alu;
  import fixed_point_pkg::*;

  localparam int I = Q_INT_WIDTH;
  localparam int F = Q_FRAC_WIDTH;
  localparam int N = I + F;
  localparam int DivLat = N + F + 2;
  localparam longint MaxV = (longint'(1) << (N - 1)) - 1;
  localparam longint MinV = -(longint'(1) << (N - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] result;
  logic         done;

  fixed_point_alu #(
    .INTEGER_PART_WIDTH   (I),
    .FRACTIONAL_PART_WIDTH(F)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .result(result),
    .done  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Monitor state, written by the stimulus when a request is accepted.
  bit           mon_skip = 1'b1;
  bit           pending  = 1'b0;
  int           cyc      = 0;
  int           exp_lat  = 0;
  logic [N-1:0] exp_res  = '0;
  logic [N-1:0] held     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic longint sx(input logic [N-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic logic [N-1:0] sat(input longint v);
    if (v > MaxV) return Q_MAX;
    if (v < MinV) return Q_MIN;
    return v[N-1:0];
  endfunction

  function automatic logic [N-1:0] mul_m(input logic [N-1:0] x, input logic [N-1:0] y);
    return sat((sx(x) * sx(y)) >>> F);
  endfunction

  function automatic logic [N-1:0] div_m(input logic [N-1:0] x, input logic [N-1:0] y);
    if (sx(y) == 0) begin
      if (sx(x) > 0) return Q_MAX;
      if (sx(x) < 0) return Q_MIN;
      return '0;
    end
    return sat((sx(x) * (longint'(1) << F)) / sx(y));
  endfunction

  function automatic logic [N-1:0] pow_m(input logic [N-1:0] x, input logic [N-1:0] y);
    longint       k;
    longint       mag;
    logic [N-1:0] acc;
    k = sx(y) >>> F;
    if (k == 0) return Q_ONE;
    mag = (k < 0) ? -k : k;
    acc = x;
    for (longint i = 1; i < mag; i++) acc = mul_m(acc, x);
    if (k < 0) acc = div_m(Q_ONE, acc);
    return acc;
  endfunction

  function automatic logic [N-1:0] model(input logic [2:0] o, input logic [N-1:0] x,
                                         input logic [N-1:0] y);
    case (o)
      OP_ADD:  return sat(sx(x) + sx(y));
      OP_SUB:  return sat(sx(x) - sx(y));
      OP_MUL:  return mul_m(x, y);
      OP_DIV:  return div_m(x, y);
      OP_POW:  return pow_m(x, y);
      default: return '0;
    endcase
  endfunction

  // -1 marks a data-dependent latency.
  function automatic int lat_m(input logic [2:0] o);
    case (o)
      OP_MUL:  return 2;
      OP_DIV:  return DivLat;
      OP_POW:  return -1;
      default: return 1;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit want_done;
    if (!mon_skip) begin
      want_done = pending && ((exp_lat < 0) ? (done === 1'b1) : (cyc == exp_lat));
      check("done timing", {31'b0, done}, {31'b0, want_done});
      if (done === 1'b1) begin
        if (pending) begin
          check("result at done", result, exp_res);
          held = exp_res;
        end
        pending = 1'b0;
      end else begin
        check("result hold", result, held);
      end
      if (pending) cyc++;
    end
  end

  // ---------------- stimulus helpers (all entered at posedge + 1) ----------------
  task automatic do_reset(input int n);
    mon_skip = 1'b1;
    rst      = 1'b1;
    start    = 1'b0;
    @(posedge clk); #1;
    pending  = 1'b0;
    held     = '0;
    mon_skip = 1'b0;
    repeat (n - 1) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic drive_start(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk); #1;
    pending = 1'b1;
    cyc     = 0;
    exp_res = model(o, x, y);
    exp_lat = lat_m(o);
    // Operands are latched; scramble them to prove it.
    start = 1'b0;
    op    = 3'($urandom);
    a     = N'($urandom);
    b     = N'($urandom);
  endtask

  task automatic wait_done(output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      $display("FAIL done timeout: no done after %0d cycles at %0t", n, $time);
      do_reset(2);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                     input logic [N-1:0] lit, input int lit_lat, input string name);
    int n;
    bit got;
    drive_start(o, x, y);
    wait_done(n, got);
    if (got) begin
      check(name, result, lit);
      if (lit_lat >= 0) check({name, " latency"}, n, lit_lat);
    end
  endtask

  function automatic logic [N-1:0] rnd_operand();
    int v;
    if ($urandom_range(0, 1) == 1) begin
      v = int'($urandom_range(0, 2047)) - 1024;
      return N'(v);
    end
    return N'($urandom);
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int  n;
    bit  got;
    logic [2:0] ro;
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    @(posedge clk); #1;
    do_reset(3);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 16'h0000);

    run(OP_ADD, 16'h0180, 16'h0240, 16'h03C0, 1, "add");
    run(OP_SUB, 16'h0100, 16'h0300, 16'hFE00, 1, "sub");
    run(OP_ADD, 16'h7F00, 16'h0200, 16'h7FFF, 1, "add sat");

    run(OP_MUL, 16'h0180, 16'hFE00, 16'hFD00, 2, "mul neg");
    run(OP_MUL, 16'h6400, 16'h6400, 16'h7FFF, 2, "mul sat");
    run(OP_MUL, 16'h0080, 16'h0080, 16'h0040, 2, "mul frac");

    run(OP_DIV, 16'h0300, 16'h0200, 16'h0180, DivLat, "div");
    run(OP_DIV, 16'hFD00, 16'h0200, 16'hFE80, DivLat, "div neg");
    run(OP_DIV, 16'h0100, 16'h0000, 16'h7FFF, DivLat, "div by zero");
    run(OP_DIV, 16'h0000, 16'h0000, 16'h0000, DivLat, "div zero by zero");

    run(OP_POW, 16'h0180, 16'h0200, 16'h0240, -1, "pow square");
    run(OP_POW, 16'h0200, 16'hFF00, 16'h0080, -1, "pow recip");
    run(OP_POW, 16'h0500, 16'h0000, 16'h0100, -1, "pow zero exp");
    run(OP_POW, 16'h0200, 16'h0800, 16'h7FFF, -1, "pow sat");
    run(OP_POW, 16'h0200, 16'h0280, 16'h0400, -1, "pow frac exp");
    run(OP_POW, 16'h0000, 16'hFE00, 16'h7FFF, -1, "pow zero neg exp");

    // Back-to-back: each start below is issued while done is still high.
    check("b2b done cycle", {31'b0, done}, 32'd1);
    run(3'd5, 16'h1234, 16'h5678, 16'h0000, 1, "reserved 5");
    run(3'd7, 16'h7FFF, 16'h7FFF, 16'h0000, 1, "reserved 7");

    // A start while a division is running must be ignored.
    drive_start(OP_DIV, 16'h0300, 16'h0200);
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    op    = OP_ADD;
    a     = 16'h0001;
    b     = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, got);
    if (got) begin
      check("busy start ignored result", result, 16'h0180);
      check("busy start ignored latency", n + 4, DivLat);
    end
    repeat (4) begin
      @(posedge clk); #1;
    end

    // Reset in the middle of a division: no done, result cleared.
    drive_start(OP_DIV, 16'h0700, 16'h0300);
    repeat (5) begin
      @(posedge clk); #1;
    end
    do_reset(2);
    repeat (DivLat + 4) begin
      @(posedge clk); #1;
    end
    check("abort result", result, 16'h0000);
    check("abort done", {31'b0, done}, 32'd0);

    // Random ADD/MUL/DIV traffic checked by the monitor against the model.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       ro = OP_ADD;
        1:       ro = OP_MUL;
        default: ro = OP_DIV;
      endcase
      drive_start(ro, rnd_operand(), rnd_operand());
      wait_done(n, got);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passes, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
